reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_file_if.sv | 26 ++
 rtl/reg_file_rdport.sv | 37 +++
 rtl/reg_file.sv | 59 +++++
 tb/tb_reg_file.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the reg_file slice: default widths, register count and
// the hardwired-zero register address.
package reg_file_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

   localparam logic [ADDR_W_DEF-1:0] ZERO_REG = {ADDR_W_DEF{1'b0}};

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bus: two read ports and one write port.
// The master drives the addresses and write data, and the slave returns read data.
interface reg_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);

   logic [ADDR_W-1:0] A1;
   logic [ADDR_W-1:0] A2;
   logic [ADDR_W-1:0] WriteReg;
   logic [DATA_W-1:0] WD;
   logic              WE;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;

   modport master (
      output A1, A2, WriteReg, WD, WE,
      input  RD1, RD2
   );

   modport slave (
      input  A1, A2, WriteReg, WD, WE,
      output RD1, RD2
   );

endinterface

// File: rtl/reg_file_rdport.sv
// One combinational read port: decodes the address, forces register 0 to zero and,
// when REGFILE_BYPASS_EN is defined, forwards in-flight write data.
module reg_file_rdport
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0]                    addr,
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
`ifdef REGFILE_BYPASS_EN
   input  logic                                 byp_en,
   input  logic [ADDR_W-1:0]                    wr_addr,
   input  logic [DATA_W-1:0]                    wd,
`endif
   output logic [DATA_W-1:0]                    rd
);

   logic [DATA_W-1:0] rd_s;

   // Select the read value; register 0 always wins over any other source
   always_comb begin
      rd_s = {DATA_W{1'b0}};
      if (addr == ADDR_W'(ZERO_REG)) begin
         rd_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (byp_en && (addr == wr_addr)) begin
         rd_s = wd;
`endif
      end else begin
         rd_s = regs[addr];
      end
   end

   assign rd = rd_s;

endmodule

// File: rtl/reg_file.sv
// Register file: 2**ADDR_W registers, two combinational reads and one synchronous write.
// Register 0 reads as zero. Define REGFILE_BYPASS_EN to forward write data to reads in the same cycle.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   reg_file_if.slave   bus
);

   localparam int NUM_R = 2 ** ADDR_W;

   logic [NUM_R-1:0][DATA_W-1:0] regs_r;
   logic                         wr_ok_s;

   assign wr_ok_s = bus.WE && (bus.WriteReg != ADDR_W'(ZERO_REG));

   // Storage update: reset clears everything and takes priority over a write
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_r <= {(NUM_R*DATA_W){1'b0}};
      end else if (wr_ok_s) begin
         regs_r[bus.WriteReg] <= bus.WD;
      end else begin
         regs_r <= regs_r;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic byp_en_s;
   assign byp_en_s = wr_ok_s && !rst;
`endif

   reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
      .addr    (bus.A1),
      .regs    (regs_r),
`ifdef REGFILE_BYPASS_EN
      .byp_en  (byp_en_s),
      .wr_addr (bus.WriteReg),
      .wd      (bus.WD),
`endif
      .rd      (bus.RD1)
   );

   reg_file_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
      .addr    (bus.A2),
      .regs    (regs_r),
`ifdef REGFILE_BYPASS_EN
      .byp_en  (byp_en_s),
      .wr_addr (bus.WriteReg),
      .wd      (bus.WD),
`endif
      .rd      (bus.RD2)
   );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, a reset sweep, then random
// traffic checked against an array model. Works with and without REGFILE_BYPASS_EN.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] model [32];

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic        chk_pre;
      logic [31:0] p1;
      logic [31:0] p2;
      logic [31:0] q1;
      logic [31:0] q2;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (BYP && bus.WE && !rst && bus.WriteReg != 5'd0 && a == bus.WriteReg) return bus.WD;
      return model[a];
   endfunction

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'd0;
      end else if (bus.WE && bus.WriteReg != 5'd0) begin
         model[bus.WriteReg] = bus.WD;
      end
   endtask

   task automatic drive(input logic r, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      rst = r;
      bus.WE = we;
      bus.WriteReg = wr;
      bus.WD = wd;
      bus.A1 = a1;
      bus.A2 = a2;
      #2;
   endtask

   task automatic clock_edge();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      rst = 1'b0;
      bus.WE = 1'b0;
      bus.WriteReg = 5'd0;
      bus.WD = 32'd0;
      bus.A1 = 5'd0;
      bus.A2 = 5'd0;

      //          rst   we    wr     wd        a1     a2     pre   p1                    p2       q1       q2
      vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'd0,   5'd1,  5'd2,  1'b0, 32'd0,                32'd0,   32'd0,   32'd0};
      vecs[1]  = '{1'b0, 1'b1, 5'd2,  32'd40,  5'd2,  5'd3,  1'b1, BYP ? 32'd40  : 32'd0, 32'd0,   32'd40,  32'd0};
      vecs[2]  = '{1'b0, 1'b1, 5'd4,  32'd80,  5'd4,  5'd2,  1'b1, BYP ? 32'd80  : 32'd0, 32'd40,  32'd80,  32'd40};
      vecs[3]  = '{1'b0, 1'b1, 5'd8,  32'd160, 5'd8,  5'd4,  1'b1, BYP ? 32'd160 : 32'd0, 32'd80,  32'd160, 32'd80};
      vecs[4]  = '{1'b0, 1'b1, 5'd16, 32'd320, 5'd16, 5'd8,  1'b1, BYP ? 32'd320 : 32'd0, 32'd160, 32'd320, 32'd160};
      vecs[5]  = '{1'b0, 1'b1, 5'd31, 32'd640, 5'd31, 5'd16, 1'b1, BYP ? 32'd640 : 32'd0, 32'd320, 32'd640, 32'd320};
      vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'd0,   5'd2,  5'd4,  1'b1, 32'd40,               32'd80,  32'd40,  32'd80};
      vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'd0,   5'd8,  5'd16, 1'b1, 32'd160,              32'd320, 32'd160, 32'd320};
      vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'd0,   5'd31, 5'd2,  1'b1, 32'd640,              32'd40,  32'd640, 32'd40};
      vecs[9]  = '{1'b0, 1'b1, 5'd0,  32'd20,  5'd0,  5'd0,  1'b1, 32'd0,                32'd0,   32'd0,   32'd0};
      vecs[10] = '{1'b0, 1'b0, 5'd4,  32'd999, 5'd4,  5'd4,  1'b1, 32'd80,               32'd80,  32'd80,  32'd80};
      vecs[11] = '{1'b0, 1'b0, 5'd0,  32'd0,   5'd31, 5'd31, 1'b1, 32'd640,              32'd640, 32'd640, 32'd640};
      vecs[12] = '{1'b0, 1'b1, 5'd7,  32'd77,  5'd7,  5'd31, 1'b1, BYP ? 32'd77  : 32'd0, 32'd640, 32'd77,  32'd640};
      vecs[13] = '{1'b1, 1'b1, 5'd3,  32'd5,   5'd3,  5'd7,  1'b1, 32'd0,                32'd77,  32'd0,   32'd0};
      vecs[14] = '{1'b0, 1'b1, 5'd3,  32'd5,   5'd3,  5'd0,  1'b1, BYP ? 32'd5   : 32'd0, 32'd0,   32'd5,   32'd0};

      // Directed table; the reset sweep is slotted in right after the reset entry 13
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].rst, vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].a1, vecs[i].a2);
         if (vecs[i].chk_pre) begin
            chk($sformatf("vec%0d_pre_rd1", i), bus.RD1, vecs[i].p1);
            chk($sformatf("vec%0d_pre_rd2", i), bus.RD2, vecs[i].p2);
         end
         clock_edge();
         chk($sformatf("vec%0d_post_rd1", i), bus.RD1, vecs[i].q1);
         chk($sformatf("vec%0d_post_rd2", i), bus.RD2, vecs[i].q2);
         if (i == 13) begin
            for (int a = 1; a < 32; a++) begin
               bus.WE = 1'b0;
               bus.A1 = 5'(a);
               bus.A2 = 5'(32 - a);
               #1;
               chk($sformatf("rst_sweep_r%0d", a), bus.RD1, 32'd0);
               chk($sformatf("rst_sweep_r%0d_p2", 32 - a), bus.RD2, 32'd0);
            end
         end
      end

      // Randomised traffic against the array model
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
               1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)),
               $urandom(),
               5'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0) ? bus.WriteReg : 5'($urandom_range(0, 31)));
         chk("rand_pre_rd1", bus.RD1, model_rd(bus.A1));
         chk("rand_pre_rd2", bus.RD2, model_rd(bus.A2));
         clock_edge();
         chk("rand_post_rd1", bus.RD1, model_rd(bus.A1));
         chk("rand_post_rd2", bus.RD2, model_rd(bus.A2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
